// File: rtl/zap_wb_arbiter.sv
// Two-master (instruction/data) to one-slave Wishbone arbiter for the ZAP core.
// Round-robin, holds the grant for a whole cyc envelope, and a watchdog aborts stalled strobes.
module zap_wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_instr_wb_cyc,
  input  logic        i_instr_wb_stb,
  input  logic        i_instr_wb_we,
  input  logic [31:0] i_instr_wb_adr,
  input  logic [3:0]  i_instr_wb_sel,
  input  logic [31:0] i_instr_wb_dat,
  output logic [31:0] o_instr_wb_dat,
  output logic        o_instr_wb_ack,
  output logic        o_instr_wb_err,
  input  logic        i_data_wb_cyc,
  input  logic        i_data_wb_stb,
  input  logic        i_data_wb_we,
  input  logic [31:0] i_data_wb_adr,
  input  logic [3:0]  i_data_wb_sel,
  input  logic [31:0] i_data_wb_dat,
  output logic [31:0] o_data_wb_dat,
  output logic        o_data_wb_ack,
  output logic        o_data_wb_err,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_adr,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_dat,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DRAIN} state_e;

  localparam logic [15:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);
  localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;   // last granted master, 1 = data; also the owner in GNT/DRAIN
  logic [15:0] cnt_q, cnt_d;

  logic        own_cyc, own_stb, own_we, resp, expire;
  logic [31:0] own_adr, own_dat;
  logic [3:0]  own_sel;

  assign o_instr_wb_dat = i_wb_dat;
  assign o_data_wb_dat  = i_wb_dat;

  assign own_cyc = ptr_q ? i_data_wb_cyc : i_instr_wb_cyc;
  assign own_stb = ptr_q ? i_data_wb_stb : i_instr_wb_stb;
  assign own_we  = ptr_q ? i_data_wb_we  : i_instr_wb_we;
  assign own_adr = ptr_q ? i_data_wb_adr : i_instr_wb_adr;
  assign own_sel = ptr_q ? i_data_wb_sel : i_instr_wb_sel;
  assign own_dat = ptr_q ? i_data_wb_dat : i_instr_wb_dat;
  assign resp    = i_wb_ack | i_wb_err;

  // An owner dropping cyc in the expiry cycle wins: that transfer simply ends.
  assign expire = TO_EN && (state_q == GNT_I || state_q == GNT_D) && own_cyc && own_stb
                  && !resp && (cnt_q == TO_LAST);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    cnt_d          = 16'd0;
    o_wb_cyc       = 1'b0;
    o_wb_stb       = 1'b0;
    o_wb_we        = 1'b0;
    o_wb_adr       = 32'd0;
    o_wb_sel       = 4'd0;
    o_wb_dat       = 32'd0;
    o_instr_wb_ack = 1'b0;
    o_instr_wb_err = 1'b0;
    o_data_wb_ack  = 1'b0;
    o_data_wb_err  = 1'b0;
    o_grant        = 2'b00;
    o_timeout      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_instr_wb_cyc && (!i_data_wb_cyc || ptr_q)) begin
          state_d = GNT_I;
          ptr_d   = 1'b0;
        end else if (i_data_wb_cyc) begin
          state_d = GNT_D;
          ptr_d   = 1'b1;
        end
      end
      GNT_I, GNT_D: begin
        o_grant   = ptr_q ? 2'b10 : 2'b01;
        o_wb_cyc  = own_cyc & ~expire;
        o_wb_stb  = own_stb & ~expire;
        o_wb_we   = own_we;
        o_wb_adr  = own_adr;
        o_wb_sel  = own_sel;
        o_wb_dat  = own_dat;
        o_timeout = expire;
        if (ptr_q) begin
          o_data_wb_ack  = i_wb_ack;
          o_data_wb_err  = i_wb_err | expire;
        end else begin
          o_instr_wb_ack = i_wb_ack;
          o_instr_wb_err = i_wb_err | expire;
        end
        if (!own_cyc)                state_d = IDLE;
        else if (expire)             state_d = DRAIN;
        else if (resp || !own_stb)   cnt_d   = 16'd0;
        else                         cnt_d   = cnt_q + 16'd1;
      end
      DRAIN: begin
        if (!own_cyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Scoreboard bench for zap_wb_arbiter: per-master queues of expected read data plus a
// compressed grant trace checked against the round-robin / envelope / watchdog behaviour.
module tb_zap_wb_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [1:0]  m_cyc = 2'b00, m_stb = 2'b00;
  logic [31:0] m_adr [2];
  logic [31:0] o_instr_wb_dat, o_data_wb_dat, o_wb_adr, o_wb_dat, i_wb_dat;
  logic        o_instr_wb_ack, o_instr_wb_err, o_data_wb_ack, o_data_wb_err;
  logic        o_wb_cyc, o_wb_stb, o_wb_we, i_wb_ack, o_timeout;
  logic        i_wb_err = 1'b0;
  logic [3:0]  o_wb_sel;
  logic [1:0]  o_grant, m_ack;

  logic        slv_en = 1'b1;
  logic        stall_q;
  logic        rec_clr = 1'b1;
  logic [31:0] q0[$], q1[$];
  logic [1:0]  gs_val[$], ex_val[$];
  int          gs_len[$], ex_len[$];
  int          n_tot = 0, n_bad = 0;

  always #5 i_clk = ~i_clk;

  zap_wb_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_instr_wb_cyc(m_cyc[0]), .i_instr_wb_stb(m_stb[0]), .i_instr_wb_we(1'b0),
    .i_instr_wb_adr(m_adr[0]), .i_instr_wb_sel(4'hF), .i_instr_wb_dat(32'h0),
    .o_instr_wb_dat(o_instr_wb_dat), .o_instr_wb_ack(o_instr_wb_ack), .o_instr_wb_err(o_instr_wb_err),
    .i_data_wb_cyc(m_cyc[1]), .i_data_wb_stb(m_stb[1]), .i_data_wb_we(1'b0),
    .i_data_wb_adr(m_adr[1]), .i_data_wb_sel(4'hF), .i_data_wb_dat(32'h0),
    .o_data_wb_dat(o_data_wb_dat), .o_data_wb_ack(o_data_wb_ack), .o_data_wb_err(o_data_wb_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_adr(o_wb_adr),
    .o_wb_sel(o_wb_sel), .o_wb_dat(o_wb_dat), .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack),
    .i_wb_err(i_wb_err), .o_grant(o_grant), .o_timeout(o_timeout)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  // Slave model: acks each beat in its second strobed cycle.
  assign i_wb_ack = slv_en & stall_q;
  assign i_wb_dat = mem(o_wb_adr);
  assign m_ack    = {o_data_wb_ack, o_instr_wb_ack};

  always @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) stall_q <= 1'b0;
    else            stall_q <= slv_en & o_wb_stb & ~i_wb_ack;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard pop on every master ack, plus run-length grant trace.
  always @(negedge i_clk) begin
    if (o_instr_wb_ack) chk("i_rdat", o_instr_wb_dat, (q0.size() != 0) ? q0.pop_front() : 32'hBAD0BAD0);
    if (o_data_wb_ack)  chk("d_rdat", o_data_wb_dat,  (q1.size() != 0) ? q1.pop_front() : 32'hBAD1BAD1);
    if (rec_clr) begin
      gs_val.delete();
      gs_len.delete();
    end else if (gs_val.size() == 0 || o_grant != gs_val[gs_val.size()-1]) begin
      gs_val.push_back(o_grant);
      gs_len.push_back(1);
    end else begin
      gs_len.push_back(gs_len.pop_back() + 1);
    end
  end

  task automatic trace_start();
    rec_clr = 1'b1;
    @(negedge i_clk);
    @(posedge i_clk); #1;
    rec_clr = 1'b0;
  endtask

  // ex_len < 0 means "don't care" (the trailing idle run).
  task automatic chk_trace(input string tag);
    for (int i = 0; i < ex_val.size(); i++) begin
      chk({tag, "_g"}, (i < gs_val.size()) ? 32'(gs_val[i]) : 32'h3, 32'(ex_val[i]));
      if (ex_len[i] >= 0)
        chk({tag, "_len"}, (i < gs_len.size()) ? gs_len[i] : -1, ex_len[i]);
    end
  endtask

  task automatic xfer(input int m, input logic [31:0] base, input int nb);
    int w;
    m_cyc[m] = 1'b1;
    for (int b = 0; b < nb; b++) begin
      m_stb[m] = 1'b1;
      m_adr[m] = base + 32'(4 * b);
      if (m == 0) q0.push_back(mem(m_adr[m]));
      else        q1.push_back(mem(m_adr[m]));
      w = 0;
      do begin @(negedge i_clk); w++; end while (!m_ack[m] && w < 100);
      chk($sformatf("ack_m%0d", m), {31'b0, m_ack[m]}, 32'd1);
      @(posedge i_clk); #1;
    end
    m_stb[m] = 1'b0;
    m_cyc[m] = 1'b0;
  endtask

  initial begin
    int w;
    m_adr[0] = 32'h0;
    m_adr[1] = 32'h0;
    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst_out", {o_wb_cyc, o_wb_stb, o_wb_we, o_grant, o_timeout, o_instr_wb_ack,
                    o_instr_wb_err, o_data_wb_ack, o_data_wb_err}, 32'd0);
    chk("rst_adr", o_wb_adr | o_wb_dat | 32'(o_wb_sel), 32'd0);
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;

    // Single instruction read at 0x100
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h100;
    q0.push_back(32'hDEADBEEF);
    @(negedge i_clk); chk("rd_g0", 32'(o_grant), 32'd0);
    @(posedge i_clk); #1;
    @(negedge i_clk); chk("rd_g1", 32'(o_grant), 32'd1);
    chk("rd_adr1", o_wb_adr, 32'h100);
    chk("rd_ack1", {30'b0, o_data_wb_ack, o_instr_wb_ack}, 32'd0);
    @(posedge i_clk); #1;
    @(negedge i_clk); chk("rd_ack2", {30'b0, o_data_wb_ack, o_instr_wb_ack}, 32'd1);
    @(posedge i_clk); #1;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    repeat (2) @(posedge i_clk); #1;

    // Tie after reset: data first, one idle cycle, then instruction
    trace_start();
    fork
      xfer(0, 32'h10, 1);
      xfer(1, 32'h20, 1);
    join
    repeat (2) @(posedge i_clk); #1;
    ex_val = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    ex_len = '{1, 3, 1, 3, -1};
    chk_trace("tie");

    // Round-robin with both masters re-requesting
    trace_start();
    fork
      begin xfer(0, 32'h30, 1); @(posedge i_clk); #1; xfer(0, 32'h34, 1); end
      begin xfer(1, 32'h40, 1); @(posedge i_clk); #1; xfer(1, 32'h44, 1); end
    join
    repeat (2) @(posedge i_clk); #1;
    ex_val = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    ex_len = '{1, 3, 1, 3, 1, 3, 1, 3, -1};
    chk_trace("rr");

    // Burst hold: four data beats 0x200..0x20C, instr waits for the envelope to close
    trace_start();
    fork
      xfer(1, 32'h200, 4);
      begin @(posedge i_clk); #1; xfer(0, 32'h300, 1); end
    join
    repeat (2) @(posedge i_clk); #1;
    ex_val = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    ex_len = '{1, 9, 1, 3, -1};
    chk_trace("burst");

    // Watchdog: slave silent, fires in the 8th stalled cycle
    slv_en = 1'b0;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h500;
    @(negedge i_clk);
    for (int k = 1; k <= 8; k++) begin
      @(posedge i_clk); @(negedge i_clk);
      chk($sformatf("to_c%0d", k), {29'b0, o_instr_wb_err, o_timeout, o_wb_cyc},
          (k < 8) ? 32'd1 : 32'd6);
    end
    @(posedge i_clk); #1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h400;
    q1.push_back(mem(32'h400));
    for (int k = 0; k < 2; k++) begin
      @(negedge i_clk);
      chk("drain", {27'b0, o_grant, o_wb_cyc, o_instr_wb_err, o_timeout}, 32'd0);
      @(posedge i_clk); #1;
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    @(negedge i_clk); chk("drain_m", 32'(o_grant), 32'd0);
    @(posedge i_clk); #1;
    slv_en = 1'b1;
    @(negedge i_clk); chk("drain_idle", 32'(o_grant), 32'd0);
    @(posedge i_clk); #1;
    @(negedge i_clk); chk("drain_next", 32'(o_grant), 32'd2);
    w = 0;
    while (!o_data_wb_ack && w < 50) begin @(posedge i_clk); @(negedge i_clk); w++; end
    chk("drain_ack", {31'b0, o_data_wb_ack}, 32'd1);
    @(posedge i_clk); #1;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    repeat (2) @(posedge i_clk); #1;

    // Async reset during GNT_D
    slv_en = 1'b0;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h600;
    @(posedge i_clk); #1;
    @(negedge i_clk); chk("ar_pre", {30'b0, o_grant}, 32'd2);
    chk("ar_pre_cyc", {31'b0, o_wb_cyc}, 32'd1);
    #2 i_reset_n = 1'b0;
    #1 chk("ar_cyc", {31'b0, o_wb_cyc}, 32'd0);
    chk("ar_gnt", {30'b0, o_grant}, 32'd0);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    slv_en = 1'b1;
    trace_start();
    fork
      xfer(0, 32'h700, 1);
      xfer(1, 32'h704, 1);
    join
    repeat (2) @(posedge i_clk); #1;
    ex_val = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    ex_len = '{1, 3, 1, 3, -1};
    chk_trace("ar_tie");

    chk("sb_empty", q0.size() + q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
